// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell used as the bit-slice of the serial adder.
module serial_adder_fa (
   output logic Cout,
   output logic Sum,
   input  logic A,
   input  logic B,
   input  logic Cin
);

   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, start/busy/done handshake.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output Ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sha;
   logic [WIDTH-1:0] shb;
   logic [WIDTH-1:0] shs;
   logic [WIDTH-1:0] shs_next;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_sum;
   logic             fa_cout;

   serial_adder_fa u_fa (
      .Cout (fa_cout),
      .Sum  (fa_sum),
      .A    (sha[0]),
      .B    (shb[0]),
      .Cin  (carry)
   );

   // The final result must include the bit produced on the completing edge.
   assign shs_next = {fa_sum, shs[WIDTH-1:1]};
   assign busy     = (state == ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         sha   <= '0;
         shb   <= '0;
         shs   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         Sum   <= '0;
         Cout  <= 1'b0;
         done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         Ovf   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sha   <= A;
                  shb   <= B;
                  carry <= Cin;
                  cnt   <= '0;
                  shs   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               shs   <= shs_next;
               sha   <= {1'b0, sha[WIDTH-1:1]};
               shb   <= {1'b0, shb[WIDTH-1:1]};
               carry <= fa_cout;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  Sum   <= shs_next;
                  Cout  <= fa_cout;
                  done  <= 1'b1;
                  state <= ST_IDLE;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry still holds the carry into the MSB on this edge
                  Ovf   <= carry ^ fa_cout;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
